// File: rtl/hit_judge_if.sv
// Port bundle between the note-scroll engine, the drum pads and the hit judge.
// The judge consumes note/hit inputs and returns score strobes plus display state.
interface hit_judge_if;
  logic       note_start;
  logic       note_kind;
  logic       hit_don;
  logic       hit_ka;
  logic       increase_score;
  logic       decrease_score;
  logic [7:0] combo;
  logic [1:0] judgement;
  logic       window_open;

  modport master (
    output note_start, note_kind, hit_don, hit_ka,
    input  increase_score, decrease_score, combo, judgement, window_open
  );

  modport slave (
    input  note_start, note_kind, hit_don, hit_ka,
    output increase_score, decrease_score, combo, judgement, window_open
  );
endinterface

// File: rtl/hit_judge.sv
// Judges each drum hit against the note in the hit zone; score strobes are registered.
// Latency: raw button to strobe is 3 clocks after first sample; no backpressure, all inputs always accepted.
module hit_judge_btn (
  input  logic clk,
  input  logic resetn,
  input  logic i_raw,
  output logic o_evt
);
  logic r_s1;
  logic r_s2;
  logic r_s3;
  logic r_evt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_s3  <= 1'b0;
      r_evt <= 1'b0;
    end else begin
      r_s1  <= i_raw;
      r_s2  <= r_s1;
      r_s3  <= r_s2;
      r_evt <= r_s2 & ~r_s3;
    end
  end

  assign o_evt = r_evt;
endmodule

module hit_judge #(
  parameter logic [23:0] WINDOW_CYCLES  = 24'd5000000,
  parameter logic        PENALIZE_STRAY = 1'b0
) (
  input logic        clk,
  input logic        resetn,
  hit_judge_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_OPEN   = 2'd1,
    S_JUDGED = 2'd2
  } state_t;

  localparam logic [1:0]  J_NONE = 2'b00;
  localparam logic [1:0]  J_GOOD = 2'b01;
  localparam logic [1:0]  J_BAD  = 2'b10;
  localparam logic [1:0]  J_MISS = 2'b11;
  localparam logic [23:0] LAST   = WINDOW_CYCLES - 24'd1;

  state_t      r_state;
  logic [23:0] r_cnt;
  logic        r_kind;
  logic        r_inc;
  logic        r_dec;
  logic [7:0]  r_combo;
  logic [1:0]  r_judg;

  logic w_don;
  logic w_ka;
  logic w_any;
  logic w_match;
  logic w_last;
  logic [7:0] w_combo_inc;

  hit_judge_btn u_btn_don (.clk(clk), .resetn(resetn), .i_raw(bus.hit_don), .o_evt(w_don));
  hit_judge_btn u_btn_ka  (.clk(clk), .resetn(resetn), .i_raw(bus.hit_ka),  .o_evt(w_ka));

  // A simultaneous don+ka is never a match, so it falls into the wrong-hit path.
  assign w_any       = w_don | w_ka;
  assign w_match     = r_kind ? (w_ka & ~w_don) : (w_don & ~w_ka);
  assign w_last      = (r_cnt == LAST);
  assign w_combo_inc = (r_combo == 8'hFF) ? r_combo : r_combo + 8'd1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= 24'd0;
      r_kind  <= 1'b0;
      r_inc   <= 1'b0;
      r_dec   <= 1'b0;
      r_combo <= 8'd0;
      r_judg  <= J_NONE;
    end else begin
      r_inc <= 1'b0;
      r_dec <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any && PENALIZE_STRAY) begin
            r_dec   <= 1'b1;
            r_judg  <= J_BAD;
            r_combo <= 8'd0;
          end
          if (bus.note_start) begin
            r_state <= S_OPEN;
            r_kind  <= bus.note_kind;
            r_cnt   <= 24'd0;
          end
        end

        S_OPEN: begin
          r_cnt <= r_cnt + 24'd1;
          if (w_any) begin
            if (w_match) begin
              r_inc   <= 1'b1;
              r_judg  <= J_GOOD;
              r_combo <= w_combo_inc;
            end else begin
              r_dec   <= 1'b1;
              r_judg  <= J_BAD;
              r_combo <= 8'd0;
            end
            // A hit on the final window cycle also ends the window.
            r_state <= w_last ? S_IDLE : S_JUDGED;
          end else if (w_last || bus.note_start) begin
            r_dec   <= 1'b1;
            r_judg  <= J_MISS;
            r_combo <= 8'd0;
            r_state <= S_IDLE;
          end
          if (bus.note_start) begin
            r_state <= S_OPEN;
            r_kind  <= bus.note_kind;
            r_cnt   <= 24'd0;
          end
        end

        S_JUDGED: begin
          r_cnt <= r_cnt + 24'd1;
          if (bus.note_start) begin
            r_state <= S_OPEN;
            r_kind  <= bus.note_kind;
            r_cnt   <= 24'd0;
          end else if (w_last) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 24'd0;
        end
      endcase
    end
  end

  assign bus.increase_score = r_inc;
  assign bus.decrease_score = r_dec;
  assign bus.combo          = r_combo;
  assign bus.judgement      = r_judg;
  assign bus.window_open    = (r_state == S_OPEN);
endmodule
